input_shift_register: RTL and testbench

- Receive-direction counterpart of output_shift_register inside each PIO state machine.
- Accumulates bits from a selected source (pins, x, y, null) under IN instructions into a 32-bit ISR.
- Pushes completed words into the RX FIFO, either explicitly (PUSH) or automatically (autopush at threshold).
- Raises stall to the fsm while a push cannot complete.

---
 rtl/input_shift_register.sv | 153 +++++++++++++++
 tb/tb_input_shift_register.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_shift_register.sv
// ---------------------------------------------------------------------------
// input_shift_register
//
// Receive-side shift register of a PIO state machine. IN instructions shift
// bits from the selected source into the 32-bit ISR. PUSH, or autopush at a
// threshold, moves the ISR into the RX FIFO. While a push cannot complete,
// stall tells the fsm to hold its PC and present the same instruction again.
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   data_in              IN-source bits, LSB-aligned
//   shift_en/shift_count IN instruction; count 0 = no-op, >WIDTH clamps
//   shiftdir             0 = left (new bits enter LSB), 1 = right (enter MSB)
//   autopush/push_thresh autopush enable; threshold 0 means WIDTH
//   push_en/push_block   explicit PUSH; block (1) or drop (0) when FIFO full
//   mov/mov_in           01 load ISR from mov_in, 10 clear ISR, else none
//   mov_out, fifo_data   both equal isr
//   fifo_full/fifo_push  RX FIFO handshake (see below)
//   stall                fsm must hold PC and re-present the instruction
//   isr                  current shift register
//   input_shift_counter  bits accumulated, 0..WIDTH, saturating
//   fsm_state            FSM state for observation: 0 = IDLE, 1 = WAIT
//
// FIFO handshake: fifo_push acts as valid and !fifo_full acts as ready.
// fifo_push is asserted only when fifo_full is low, so every clk edge that
// sees fifo_push=1 is a completed transfer. On that edge the FIFO captures
// fifo_data, and the ISR and counter clear. fifo_push never waits for ready.
// ---------------------------------------------------------------------------
module input_shift_register #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             shift_en,
    input  logic [5:0]       shift_count,
    input  logic             shiftdir,
    input  logic             autopush,
    input  logic [5:0]       push_thresh,
    input  logic             push_en,
    input  logic             push_block,
    input  logic [1:0]       mov,
    input  logic [WIDTH-1:0] mov_in,
    output logic [WIDTH-1:0] mov_out,
    input  logic             fifo_full,
    output logic             fifo_push,
    output logic [WIDTH-1:0] fifo_data,
    output logic             stall,
    output logic [WIDTH-1:0] isr,
    output logic [5:0]       input_shift_counter,
    output logic             fsm_state
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] isr_d;
    logic [5:0]       cnt_d;

    logic [5:0]       thr_eff;
    logic [5:0]       n;
    logic [6:0]       cnt_sum;
    logic             auto_pending;
    logic             mov_active;
    logic             push_req;
    logic [WIDTH-1:0] shifted;

    assign mov_out   = isr;
    assign fifo_data = isr;
    assign fsm_state = state;

    always_comb begin
        thr_eff = push_thresh;
        if (push_thresh == 6'd0 || push_thresh > 6'(WIDTH)) begin
            thr_eff = 6'(WIDTH);
        end
        n = shift_count;
        if (shift_count > 6'(WIDTH)) begin
            n = 6'(WIDTH);
        end
    end

    assign auto_pending = autopush && (input_shift_counter >= thr_eff);
    assign mov_active   = (mov == 2'b01) || (mov == 2'b10);
    // A MOV in the same cycle takes priority over PUSH. The PUSH is then
    // dropped entirely, so it must not strobe the FIFO or raise stall.
    assign push_req     = (state == IDLE) && !auto_pending && !mov_active && push_en;
    assign cnt_sum      = {1'b0, input_shift_counter} + {1'b0, n};

    // Both outputs are held low during reset, even if a PUSH is presented.
    assign fifo_push = !rst && !fifo_full &&
                       ((state == WAIT) || auto_pending || push_req);
    assign stall     = !rst &&
                       ((state == WAIT) || auto_pending ||
                        (push_req && push_block && fifo_full));

    // Shift datapath. This path is used only for 0 < n < WIDTH. A full-width
    // shift replaces the ISR outright, so it needs no out-of-range shift.
    always_comb begin
        shifted = '0;
        if (!shiftdir) begin
            shifted = (isr << n) | (data_in & ~({WIDTH{1'b1}} << n));
        end else begin
            shifted = (isr >> n) | (data_in << (6'(WIDTH) - n));
        end
    end

    always_comb begin
        state_d = state;
        isr_d   = isr;
        cnt_d   = input_shift_counter;
        if (fifo_push) begin
            state_d = IDLE;
            isr_d   = '0;
            cnt_d   = '0;
        end else if (state == IDLE && !auto_pending) begin
            if (mov == 2'b01) begin
                isr_d = mov_in;
                cnt_d = '0;
            end else if (mov == 2'b10) begin
                isr_d = '0;
                cnt_d = '0;
            end else if (push_en) begin
                // The not-full case was already taken by fifo_push above.
                if (push_block) begin
                    state_d = WAIT;
                end else begin
                    isr_d = '0;
                    cnt_d = '0;
                end
            end else if (shift_en && n != 6'd0) begin
                isr_d = (n == 6'(WIDTH)) ? data_in : shifted;
                cnt_d = (cnt_sum > 7'(WIDTH)) ? 6'(WIDTH) : cnt_sum[5:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            isr                 <= '0;
            input_shift_counter <= '0;
        end else begin
            state               <= state_d;
            isr                 <= isr_d;
            input_shift_counter <= cnt_d;
        end
    end

endmodule

// File: tb/tb_input_shift_register.sv
module tb_input_shift_register;

    logic        clk;
    logic        rst;
    logic [31:0] data_in;
    logic        shift_en;
    logic [5:0]  shift_count;
    logic        shiftdir;
    logic        autopush;
    logic [5:0]  push_thresh;
    logic        push_en;
    logic        push_block;
    logic [1:0]  mov;
    logic [31:0] mov_in;
    logic [31:0] mov_out;
    logic        fifo_full;
    logic        fifo_push;
    logic [31:0] fifo_data;
    logic        stall;
    logic [31:0] isr;
    logic [5:0]  input_shift_counter;
    logic        fsm_state;

    int tests;
    int fails;

    input_shift_register #(.WIDTH(32)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .data_in             (data_in),
        .shift_en            (shift_en),
        .shift_count         (shift_count),
        .shiftdir            (shiftdir),
        .autopush            (autopush),
        .push_thresh         (push_thresh),
        .push_en             (push_en),
        .push_block          (push_block),
        .mov                 (mov),
        .mov_in              (mov_in),
        .mov_out             (mov_out),
        .fifo_full           (fifo_full),
        .fifo_push           (fifo_push),
        .fifo_data           (fifo_data),
        .stall               (stall),
        .isr                 (isr),
        .input_shift_counter (input_shift_counter),
        .fsm_state           (fsm_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic idle_inputs();
        data_in     = '0;
        shift_en    = 1'b0;
        shift_count = '0;
        shiftdir    = 1'b0;
        autopush    = 1'b0;
        push_thresh = '0;
        push_en     = 1'b0;
        push_block  = 1'b0;
        mov         = 2'b00;
        mov_in      = '0;
        fifo_full   = 1'b0;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_isr();
        idle_inputs();
        mov = 2'b10;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        push_en  = 1'b1;
        shift_en = 1'b1;
        shift_count = 6'd8;
        data_in = 32'hFF;
        @(negedge clk);
        tests++; if (isr !== 32'h0) begin fails++; $display("FAIL reset_isr: got %h want %h", isr, 32'h0); end
        tests++; if (input_shift_counter !== 6'd0) begin fails++; $display("FAIL reset_cnt: got %0d want 0", input_shift_counter); end
        tests++; if (fifo_push !== 1'b0) begin fails++; $display("FAIL reset_push: got %b want 0", fifo_push); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", stall); end
        tests++; if (fsm_state !== 1'b0) begin fails++; $display("FAIL reset_state: got %b want 0", fsm_state); end
        idle_inputs();
        rst = 1'b0;
        tick();
        tests++; if (isr !== 32'h0) begin fails++; $display("FAIL reset_idle_isr: got %h want 0", isr); end
    endtask

    task automatic test_left_autopush();
        idle_inputs();
        autopush = 1'b1; push_thresh = 6'd8; shiftdir = 1'b0;
        shift_en = 1'b1; shift_count = 6'd4; data_in = 32'h0000000A;
        tick();
        tests++; if (isr !== 32'hA) begin fails++; $display("FAIL lap_isr1: got %h want %h", isr, 32'hA); end
        tests++; if (input_shift_counter !== 6'd4) begin fails++; $display("FAIL lap_cnt1: got %0d want 4", input_shift_counter); end
        data_in = 32'h00000005;
        tick();
        tests++; if (isr !== 32'hA5) begin fails++; $display("FAIL lap_isr2: got %h want %h", isr, 32'hA5); end
        tests++; if (input_shift_counter !== 6'd8) begin fails++; $display("FAIL lap_cnt2: got %0d want 8", input_shift_counter); end
        // A shift is presented during the push cycle. It must be ignored.
        data_in = 32'h0000000F;
        @(negedge clk);
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL lap_stall: got %b want 1", stall); end
        tests++; if (fifo_push !== 1'b1) begin fails++; $display("FAIL lap_push: got %b want 1", fifo_push); end
        tests++; if (fifo_data !== 32'h000000A5) begin fails++; $display("FAIL lap_data: got %h want %h", fifo_data, 32'hA5); end
        tick();
        shift_en = 1'b0;
        tests++; if (isr !== 32'h0) begin fails++; $display("FAIL lap_isr3: got %h want 0", isr); end
        tests++; if (input_shift_counter !== 6'd0) begin fails++; $display("FAIL lap_cnt3: got %0d want 0", input_shift_counter); end
        @(negedge clk);
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL lap_stall_after: got %b want 0", stall); end
        idle_inputs();
    endtask

    task automatic test_right_shift();
        clear_isr();
        shiftdir = 1'b1; shift_en = 1'b1; shift_count = 6'd8; data_in = 32'h000000C3;
        tick();
        tests++; if (isr !== 32'hC3000000) begin fails++; $display("FAIL rs_isr1: got %h want %h", isr, 32'hC3000000); end
        tests++; if (input_shift_counter !== 6'd8) begin fails++; $display("FAIL rs_cnt1: got %0d want 8", input_shift_counter); end
        shift_count = 6'd40; data_in = 32'hDEADBEEF;
        tick();
        tests++; if (isr !== 32'hDEADBEEF) begin fails++; $display("FAIL rs_isr2: got %h want %h", isr, 32'hDEADBEEF); end
        tests++; if (input_shift_counter !== 6'd32) begin fails++; $display("FAIL rs_cnt2: got %0d want 32", input_shift_counter); end
        // The counter is saturated, but the ISR still shifts.
        shift_count = 6'd4; data_in = 32'h00000005;
        tick();
        tests++; if (isr !== 32'h5DEADBEE) begin fails++; $display("FAIL rs_isr3: got %h want %h", isr, 32'h5DEADBEE); end
        tests++; if (input_shift_counter !== 6'd32) begin fails++; $display("FAIL rs_cnt3: got %0d want 32", input_shift_counter); end
        shift_count = 6'd0; data_in = 32'hFFFFFFFF;
        tick();
        tests++; if (isr !== 32'h5DEADBEE) begin fails++; $display("FAIL rs_noop: got %h want %h", isr, 32'h5DEADBEE); end
        idle_inputs();
    endtask

    task automatic test_blocking_push();
        clear_isr();
        mov = 2'b01; mov_in = 32'h00001234;
        tick();
        idle_inputs();
        push_en = 1'b1; push_block = 1'b1; fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++; if (stall !== 1'b1) begin fails++; $display("FAIL bp_stall[%0d]: got %b want 1", i, stall); end
            tests++; if (fifo_push !== 1'b0) begin fails++; $display("FAIL bp_push[%0d]: got %b want 0", i, fifo_push); end
            tick();
            tests++; if (fsm_state !== 1'b1) begin fails++; $display("FAIL bp_state[%0d]: got %b want 1", i, fsm_state); end
            tests++; if (isr !== 32'h1234) begin fails++; $display("FAIL bp_isr[%0d]: got %h want %h", i, isr, 32'h1234); end
        end
        fifo_full = 1'b0;
        @(negedge clk);
        tests++; if (fifo_push !== 1'b1) begin fails++; $display("FAIL bp_push_go: got %b want 1", fifo_push); end
        tests++; if (fifo_data !== 32'h1234) begin fails++; $display("FAIL bp_data: got %h want %h", fifo_data, 32'h1234); end
        tick();
        push_en = 1'b0;
        tests++; if (isr !== 32'h0) begin fails++; $display("FAIL bp_isr_after: got %h want 0", isr); end
        tests++; if (fsm_state !== 1'b0) begin fails++; $display("FAIL bp_state_after: got %b want 0", fsm_state); end
        @(negedge clk);
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL bp_stall_after: got %b want 0", stall); end
        idle_inputs();
    endtask

    task automatic test_nonblocking_full();
        clear_isr();
        mov = 2'b01; mov_in = 32'h00001234;
        tick();
        idle_inputs();
        shift_en = 1'b1; shift_count = 6'd4; data_in = 32'h5;
        tick();
        tests++; if (isr !== 32'h00012345) begin fails++; $display("FAIL nb_isr_pre: got %h want %h", isr, 32'h12345); end
        idle_inputs();
        push_en = 1'b1; push_block = 1'b0; fifo_full = 1'b1;
        @(negedge clk);
        tests++; if (fifo_push !== 1'b0) begin fails++; $display("FAIL nb_push: got %b want 0", fifo_push); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL nb_stall: got %b want 0", stall); end
        tick();
        tests++; if (isr !== 32'h0) begin fails++; $display("FAIL nb_isr: got %h want 0", isr); end
        tests++; if (input_shift_counter !== 6'd0) begin fails++; $display("FAIL nb_cnt: got %0d want 0", input_shift_counter); end
        tests++; if (fsm_state !== 1'b0) begin fails++; $display("FAIL nb_state: got %b want 0", fsm_state); end
        idle_inputs();
    endtask

    task automatic test_priority();
        clear_isr();
        mov = 2'b01; mov_in = 32'hCAFEF00D;
        shift_en = 1'b1; shift_count = 6'd8; data_in = 32'hFF; push_en = 1'b1;
        @(negedge clk);
        tests++; if (fifo_push !== 1'b0) begin fails++; $display("FAIL pr_push: got %b want 0", fifo_push); end
        tick();
        tests++; if (isr !== 32'hCAFEF00D) begin fails++; $display("FAIL pr_isr: got %h want %h", isr, 32'hCAFEF00D); end
        tests++; if (input_shift_counter !== 6'd0) begin fails++; $display("FAIL pr_cnt: got %0d want 0", input_shift_counter); end
        idle_inputs();
        mov = 2'b10;
        tick();
        tests++; if (isr !== 32'h0) begin fails++; $display("FAIL pr_clear: got %h want 0", isr); end
        // push_en beats shift_en in the same cycle.
        idle_inputs();
        shift_en = 1'b1; shift_count = 6'd8; data_in = 32'h77;
        tick();
        push_en = 1'b1;
        @(negedge clk);
        tests++; if (fifo_push !== 1'b1) begin fails++; $display("FAIL pr_push2: got %b want 1", fifo_push); end
        tests++; if (fifo_data !== 32'h77) begin fails++; $display("FAIL pr_data2: got %h want %h", fifo_data, 32'h77); end
        tick();
        tests++; if (isr !== 32'h0) begin fails++; $display("FAIL pr_isr2: got %h want 0", isr); end
        idle_inputs();
    endtask

    task automatic test_autopush_deassert();
        clear_isr();
        autopush = 1'b1; push_thresh = 6'd0; fifo_full = 1'b1;
        shift_en = 1'b1; shift_count = 6'd40; data_in = 32'h00000001;
        tick();
        tests++; if (input_shift_counter !== 6'd32) begin fails++; $display("FAIL ad_cnt: got %0d want 32", input_shift_counter); end
        data_in = 32'hFFFFFFFF;
        @(negedge clk);
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL ad_stall: got %b want 1", stall); end
        tests++; if (fifo_push !== 1'b0) begin fails++; $display("FAIL ad_push: got %b want 0", fifo_push); end
        tick();
        tests++; if (isr !== 32'h1) begin fails++; $display("FAIL ad_hold: got %h want 1", isr); end
        shift_en = 1'b0; autopush = 1'b0;
        @(negedge clk);
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL ad_stall_off: got %b want 0", stall); end
        tick();
        tests++; if (isr !== 32'h1) begin fails++; $display("FAIL ad_nopush: got %h want 1", isr); end
        idle_inputs();
    endtask

    task automatic test_reset_in_wait();
        clear_isr();
        mov = 2'b01; mov_in = 32'h000000AB;
        tick();
        idle_inputs();
        push_en = 1'b1; push_block = 1'b1; fifo_full = 1'b1;
        tick();
        tests++; if (fsm_state !== 1'b1) begin fails++; $display("FAIL rw_wait: got %b want 1", fsm_state); end
        #1 rst = 1'b1;
        #1;
        tests++; if (isr !== 32'h0) begin fails++; $display("FAIL rw_isr: got %h want 0", isr); end
        tests++; if (input_shift_counter !== 6'd0) begin fails++; $display("FAIL rw_cnt: got %0d want 0", input_shift_counter); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rw_stall: got %b want 0", stall); end
        tests++; if (fifo_push !== 1'b0) begin fails++; $display("FAIL rw_push: got %b want 0", fifo_push); end
        tests++; if (fsm_state !== 1'b0) begin fails++; $display("FAIL rw_state: got %b want 0", fsm_state); end
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        shift_en = 1'b1; shift_count = 6'd8; data_in = 32'h0000003C;
        tick();
        tests++; if (isr !== 32'h3C) begin fails++; $display("FAIL rw_shift: got %h want %h", isr, 32'h3C); end
        tests++; if (input_shift_counter !== 6'd8) begin fails++; $display("FAIL rw_shift_cnt: got %0d want 8", input_shift_counter); end
        idle_inputs();
    endtask

    // Scenario sequence and final report
    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_left_autopush();
        test_right_shift();
        test_blocking_push();
        test_nonblocking_full();
        test_priority();
        test_autopush_deassert();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
